// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types: operand forward selects and hazard FSM states.
package rv32i_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand hazard detect and forward-source select. Purely combinational.
// A hazard-blocked operand or x0 always reads the regfile path.
module hazard_fwd_sel
  import rv32i_pkg::*;
(
  input  logic [4:0]  rs_i,
  input  logic        rs_used_i,
  input  logic        dec_clk_en_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_prod_i,
  input  logic        ex_rd_valid_i,
  input  logic [4:0]  mem_rd_i,
  input  logic        mem_prod_i,
  input  logic        mem_rd_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        wb_w_en_i,
  input  logic [31:0] pending_i,
  output logic        hazard_o,
  output logic [1:0]  fwd_sel_o
);

  logic     nz, ex_hit, mem_hit, wb_hit, pend_hit;
  fwd_sel_t sel;

  // Match each in-flight writer against the operand and pick the youngest valid one.
  always_comb begin
    nz       = (rs_i != 5'd0);
    ex_hit   = ex_prod_i && (ex_rd_i == rs_i);
    mem_hit  = mem_prod_i && (mem_rd_i == rs_i);
    wb_hit   = wb_w_en_i && (wb_rd_i == rs_i);
    // A pending bit being retired by WB this cycle is bypassed, not stalled on.
    pend_hit = pending_i[rs_i] && !wb_hit;
    hazard_o = dec_clk_en_i && rs_used_i && nz &&
               ((ex_hit && !ex_rd_valid_i) || pend_hit);
    sel = FWD_RF;
    if (nz && !hazard_o) begin
      if (ex_hit && ex_rd_valid_i)        sel = FWD_EX;
      else if (mem_hit && mem_rd_valid_i) sel = FWD_MEM;
      else if (wb_hit)                    sel = FWD_WB;
    end
    fwd_sel_o = sel;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Operand-hazard controller for the execute stage: 32-entry pending-writeback
// scoreboard, load/CSR-use stall with watchdog, and rs1/rs2 forward selects.
// Optional build macro HAZARD_PERF_EN adds stall / forward event counters.
module hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int HOLD_MAX = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_rs1_used,
  input  logic        dec_rs2_used,
  input  logic        dec_clk_en,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rd_w_en,
  input  logic        ex_rd_valid,
  input  logic        ex_clk_en,
  input  logic [4:0]  mem_rd,
  input  logic        mem_rd_w_en,
  input  logic        mem_rd_valid,
  input  logic        mem_clk_en,
  input  logic [4:0]  wb_rd,
  input  logic        wb_w_en,
  input  logic        flush,
  output logic        force_stall,
  output logic [1:0]  fwd_rs1_sel,
  output logic [1:0]  fwd_rs2_sel,
  output logic [31:0] pending,
  output logic        hazard_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_fwd_events
`endif
);

  localparam int                CNT_W   = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(HOLD_MAX);

  hz_state_t        state_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [31:0]      pending_q, pending_d;
  logic             timeout_q;
  logic             ex_prod, mem_prod, hz_rs1, hz_rs2, hazard;

  assign ex_prod  = ex_clk_en && ex_rd_w_en && (ex_rd != 5'd0);
  assign mem_prod = mem_clk_en && mem_rd_w_en && (mem_rd != 5'd0);

  hazard_fwd_sel u_rs1 (
    .rs_i(dec_rs1), .rs_used_i(dec_rs1_used), .dec_clk_en_i(dec_clk_en),
    .ex_rd_i(ex_rd), .ex_prod_i(ex_prod), .ex_rd_valid_i(ex_rd_valid),
    .mem_rd_i(mem_rd), .mem_prod_i(mem_prod), .mem_rd_valid_i(mem_rd_valid),
    .wb_rd_i(wb_rd), .wb_w_en_i(wb_w_en), .pending_i(pending_q),
    .hazard_o(hz_rs1), .fwd_sel_o(fwd_rs1_sel)
  );

  hazard_fwd_sel u_rs2 (
    .rs_i(dec_rs2), .rs_used_i(dec_rs2_used), .dec_clk_en_i(dec_clk_en),
    .ex_rd_i(ex_rd), .ex_prod_i(ex_prod), .ex_rd_valid_i(ex_rd_valid),
    .mem_rd_i(mem_rd), .mem_prod_i(mem_prod), .mem_rd_valid_i(mem_rd_valid),
    .wb_rd_i(wb_rd), .wb_w_en_i(wb_w_en), .pending_i(pending_q),
    .hazard_o(hz_rs2), .fwd_sel_o(fwd_rs2_sel)
  );

  assign hazard         = hz_rs1 || hz_rs2;
  // A flush while holding kills the stalled instruction, so the stall drops at once.
  assign force_stall    = hazard && !((state_q == HOLD) && flush);
  assign pending        = pending_q;
  assign hazard_timeout = timeout_q;

  // Scoreboard next state: WB retires a bit, an EX producer without data sets one (set wins).
  always_comb begin
    pending_d = pending_q;
    if (wb_w_en && (wb_rd != 5'd0)) pending_d[wb_rd] = 1'b0;
    if (ex_prod && !ex_rd_valid)    pending_d[ex_rd] = 1'b1;
  end

  // Stall FSM, stall watchdog and scoreboard register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
      pending_q   <= '0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        RUN: begin
          if (hazard && !flush) begin
            state_q     <= HOLD;
            stall_cnt_q <= CNT_W'(1);
          end
        end
        HOLD: begin
          if (flush || !hazard) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
          end else if (stall_cnt_q == CNT_MAX) begin
            // Writeback never arrived: flag it and drop the scoreboard to unwedge the pipe.
            timeout_q   <= 1'b1;
            pending_q   <= '0;
            state_q     <= RUN;
            stall_cnt_q <= '0;
          end else begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q     <= RUN;
          stall_cnt_q <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_fwd_q;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
    end else begin
      if (force_stall) perf_stall_q <= perf_stall_q + 32'd1;
      if ((fwd_rs1_sel != 2'd0) || (fwd_rs2_sel != 2'd0)) perf_fwd_q <= perf_fwd_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_fwd_events   = perf_fwd_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios with literal
// expectations plus randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int HM = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  dec_rs1, dec_rs2, ex_rd, mem_rd, wb_rd;
  logic        dec_rs1_used, dec_rs2_used, dec_clk_en;
  logic        ex_rd_w_en, ex_rd_valid, ex_clk_en;
  logic        mem_rd_w_en, mem_rd_valid, mem_clk_en;
  logic        wb_w_en, flush;
  logic        force_stall, hazard_timeout;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [31:0] pending;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_fwd_events;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rstn(rstn),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_clk_en(dec_clk_en),
    .ex_rd(ex_rd), .ex_rd_w_en(ex_rd_w_en), .ex_rd_valid(ex_rd_valid), .ex_clk_en(ex_clk_en),
    .mem_rd(mem_rd), .mem_rd_w_en(mem_rd_w_en), .mem_rd_valid(mem_rd_valid), .mem_clk_en(mem_clk_en),
    .wb_rd(wb_rd), .wb_w_en(wb_w_en), .flush(flush),
    .force_stall(force_stall), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .pending(pending), .hazard_timeout(hazard_timeout)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_fwd_events(perf_fwd_events)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: scoreboard as a bit set, length of the current stall run,
  // sticky timeout flag, event totals.
  bit [31:0] m_pend;
  int        m_run;
  bit        m_tout;
  int        m_pstall, m_pfwd;
  bit        e_hz1, e_hz2, e_stall;
  logic [1:0] e_sel1, e_sel2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operand rules: stall on a data-less EX writer or an unretired scoreboard entry;
  // otherwise take the first source in age order that has valid data.
  function automatic void op_model(input logic [4:0] rs, input logic used,
                                   output bit hz, output logic [1:0] sel);
    logic [4:0] srd [3];
    bit         sact[3];
    bit         sok [3];
    bit         wb_now;
    srd[0] = ex_rd;  sact[0] = ex_clk_en && ex_rd_w_en;   sok[0] = ex_rd_valid;
    srd[1] = mem_rd; sact[1] = mem_clk_en && mem_rd_w_en; sok[1] = mem_rd_valid;
    srd[2] = wb_rd;  sact[2] = wb_w_en;                   sok[2] = 1'b1;
    hz = 0; sel = 2'd0;
    if (rs == 5'd0) return;
    wb_now = wb_w_en && (wb_rd == rs);
    if (dec_clk_en && used &&
        ((sact[0] && srd[0] == rs && !ex_rd_valid) || (m_pend[rs] && !wb_now))) begin
      hz = 1;
      return;
    end
    for (int i = 0; i < 3; i++)
      if (sact[i] && srd[i] == rs && sok[i]) begin
        sel = 2'(i + 1);
        return;
      end
  endfunction

  // Wait for the quiet half-cycle, compute expectations and compare every output.
  task automatic sample();
    @(negedge clk);
    op_model(dec_rs1, dec_rs1_used, e_hz1, e_sel1);
    op_model(dec_rs2, dec_rs2_used, e_hz2, e_sel2);
    e_stall = (e_hz1 || e_hz2) && !(m_run > 0 && flush);
    check("force_stall", {31'd0, force_stall}, {31'd0, e_stall});
    check("fwd_rs1_sel", {30'd0, fwd_rs1_sel}, {30'd0, e_sel1});
    check("fwd_rs2_sel", {30'd0, fwd_rs2_sel}, {30'd0, e_sel2});
    check("pending", pending, m_pend);
    check("hazard_timeout", {31'd0, hazard_timeout}, {31'd0, m_tout});
`ifdef HAZARD_PERF_EN
    check("perf_stall_cycles", perf_stall_cycles, 32'(m_pstall));
    check("perf_fwd_events", perf_fwd_events, 32'(m_pfwd));
`endif
  endtask

  // Apply the clock edge to the model, then move to just after the DUT edge.
  task automatic advance();
    bit [31:0] np;
    bit        haz;
    haz = e_hz1 || e_hz2;
    np  = m_pend;
    if (wb_w_en && wb_rd != 0) np[wb_rd] = 0;
    if (ex_clk_en && ex_rd_w_en && ex_rd != 0 && !ex_rd_valid) np[ex_rd] = 1;
    if (m_run == 0) begin
      if (haz && !flush) m_run = 1;
    end else if (flush || !haz) begin
      m_run = 0;
    end else if (m_run == HM) begin
      m_tout = 1; np = 0; m_run = 0;
    end else begin
      m_run++;
    end
    if (e_stall) m_pstall++;
    if (e_sel1 != 0 || e_sel2 != 0) m_pfwd++;
    m_pend = np;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0; dec_clk_en = 0;
    ex_rd = 0; ex_rd_w_en = 0; ex_rd_valid = 0; ex_clk_en = 0;
    mem_rd = 0; mem_rd_w_en = 0; mem_rd_valid = 0; mem_clk_en = 0;
    wb_rd = 0; wb_w_en = 0; flush = 0;
  endtask

  task automatic ex_prod(input logic [4:0] rd, input logic vld);
    ex_clk_en = 1; ex_rd_w_en = 1; ex_rd = rd; ex_rd_valid = vld;
  endtask

  task automatic mem_prod(input logic [4:0] rd, input logic vld);
    mem_clk_en = 1; mem_rd_w_en = 1; mem_rd = rd; mem_rd_valid = vld;
  endtask

  task automatic do_reset();
    idle();
    rstn = 0;
    @(negedge clk);
    check("rst_pending", pending, 32'd0);
    check("rst_stall", {31'd0, force_stall}, 32'd0);
    check("rst_fwd", {28'd0, fwd_rs1_sel, fwd_rs2_sel}, 32'd0);
    check("rst_timeout", {31'd0, hazard_timeout}, 32'd0);
    m_pend = 0; m_run = 0; m_tout = 0; m_pstall = 0; m_pfwd = 0;
    @(posedge clk);
    #1;
    rstn = 1;
  endtask

  initial begin
    idle();
    rstn = 1;
    #2;
    do_reset();

    // Load-use: LW x5 in EX, ADD reads x5 -> two stalls, released by WB bypass.
    ex_prod(5, 0); dec_clk_en = 1; dec_rs1 = 5; dec_rs1_used = 1;
    sample(); check("ld_stall_ex", {31'd0, force_stall}, 32'd1); advance();
    idle(); mem_prod(5, 0); dec_clk_en = 1; dec_rs1 = 5; dec_rs1_used = 1;
    sample(); check("ld_stall_mem", {31'd0, force_stall}, 32'd1);
    check("ld_pend5", {31'd0, pending[5]}, 32'd1); advance();
    idle(); wb_w_en = 1; wb_rd = 5; dec_clk_en = 1; dec_rs1 = 5; dec_rs1_used = 1;
    sample(); check("ld_release", {31'd0, force_stall}, 32'd0);
    check("ld_fwd_wb", {30'd0, fwd_rs1_sel}, 32'd3); advance();
    idle(); sample(); check("ld_pend_clr", pending, 32'd0); advance();

    // ALU back-to-back: EX then MEM forwarding.
    ex_prod(3, 1); dec_clk_en = 1; dec_rs2 = 3; dec_rs2_used = 1;
    sample(); check("alu_nostall", {31'd0, force_stall}, 32'd0);
    check("alu_fwd_ex", {30'd0, fwd_rs2_sel}, 32'd1); advance();
    idle(); mem_prod(3, 1); dec_clk_en = 1; dec_rs2 = 3; dec_rs2_used = 1;
    sample(); check("alu_fwd_mem", {30'd0, fwd_rs2_sel}, 32'd2); advance();

    // x0 never hazards or forwards.
    idle(); ex_prod(0, 0); mem_prod(0, 1); wb_w_en = 1;
    dec_clk_en = 1; dec_rs1_used = 1; dec_rs2_used = 1;
    sample(); check("x0_stall", {31'd0, force_stall}, 32'd0);
    check("x0_fwd", {28'd0, fwd_rs1_sel, fwd_rs2_sel}, 32'd0); advance();
    idle(); sample(); check("x0_pend", pending, 32'd0); advance();

    // Flush while holding: stall drops, scoreboard survives until WB.
    ex_prod(9, 0); dec_clk_en = 1; dec_rs1 = 9; dec_rs1_used = 1;
    sample(); advance();
    idle(); mem_prod(9, 0); dec_clk_en = 1; dec_rs1 = 9; dec_rs1_used = 1; flush = 1;
    sample(); check("flush_stall", {31'd0, force_stall}, 32'd0); advance();
    idle(); sample(); check("flush_pend9", {31'd0, pending[9]}, 32'd1); advance();
    wb_w_en = 1; wb_rd = 9; sample(); advance();
    idle(); sample(); check("flush_pend_clr", pending, 32'd0); advance();

    // Same-cycle set and clear of x7: set wins.
    ex_prod(7, 0); sample(); advance();
    ex_prod(7, 0); wb_w_en = 1; wb_rd = 7; sample(); advance();
    idle(); sample(); check("setclr_pend7", {31'd0, pending[7]}, 32'd1); advance();
    wb_w_en = 1; wb_rd = 7; sample(); advance();

    // Watchdog: WB never arrives. HM counted stall cycles, then the next one trips it.
    idle(); ex_prod(12, 0); dec_clk_en = 1; dec_rs1 = 12; dec_rs1_used = 1;
    sample(); check("wd_stall0", {31'd0, force_stall}, 32'd1); advance();
    idle(); dec_clk_en = 1; dec_rs1 = 12; dec_rs1_used = 1;
    for (int i = 1; i <= HM; i++) begin
      sample(); check("wd_stall", {31'd0, force_stall}, 32'd1);
      check("wd_not_yet", {31'd0, hazard_timeout}, 32'd0); advance();
    end
    sample(); check("wd_timeout", {31'd0, hazard_timeout}, 32'd1);
    check("wd_pend_clr", pending, 32'd0);
    check("wd_released", {31'd0, force_stall}, 32'd0); advance();

    // Reset mid-HOLD returns to RUN: a flush then no longer masks the stall.
    ex_prod(4, 0); dec_clk_en = 1; dec_rs1 = 4; dec_rs1_used = 1;
    sample(); advance();
    do_reset();
    ex_prod(4, 0); dec_clk_en = 1; dec_rs1 = 4; dec_rs1_used = 1; flush = 1;
    sample(); check("rst_run_flush", {31'd0, force_stall}, 32'd1); advance();

    // Randomized traffic over a small register set to provoke collisions.
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        dec_rs1 = 5'($urandom_range(7)); dec_rs2 = 5'($urandom_range(7));
        dec_rs1_used = 1'($urandom); dec_rs2_used = 1'($urandom);
        dec_clk_en = ($urandom_range(9) < 8);
        ex_rd = 5'($urandom_range(7)); ex_rd_w_en = ($urandom_range(3) != 0);
        ex_rd_valid = 1'($urandom); ex_clk_en = ($urandom_range(3) != 0);
        mem_rd = 5'($urandom_range(7)); mem_rd_w_en = 1'($urandom);
        mem_rd_valid = 1'($urandom); mem_clk_en = 1'($urandom);
        wb_rd = 5'($urandom_range(7)); wb_w_en = 1'($urandom);
        flush = ($urandom_range(9) == 0);
        sample();
        advance();
      end
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
